// File: rtl/display_update_ctrl.sv
// Display value register bank for the 8-digit seven-segment scanner: round-robin arbitration of two
// masked write sources, scanner blanking for BLANK_CYC cycles per accepted write, then commit.
module display_update_ctrl #(
    parameter int unsigned BLANK_CYC = 4,
    parameter logic [31:0] INIT_VAL  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        freeze_i,
    input  logic        req_a_i,
    input  logic [31:0] data_a_i,
    input  logic [3:0]  mask_a_i,
    input  logic        req_b_i,
    input  logic [31:0] data_b_i,
    input  logic [3:0]  mask_b_i,
    output logic        gnt_a_o,
    output logic        gnt_b_o,
    output logic        busy_o,
    output logic [7:0]  z1_o,
    output logic [7:0]  r1_o,
    output logic [7:0]  z2_o,
    output logic [7:0]  r2_o,
    output logic [7:0]  upd_cnt_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;
    localparam logic [7:0] CNT_LOAD = 8'(BLANK_CYC - 1);

    logic [0:0]  state_q,   state_d;
    logic        last_a_q,  last_a_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [31:0] shadow_q,  shadow_d;
    logic [31:0] disp_q,    disp_d;
    logic [7:0]  upd_cnt_q, upd_cnt_d;
    logic        gnt_a_q,   gnt_a_d;
    logic        gnt_b_q,   gnt_b_d;
    logic        busy_q,    busy_d;

    logic        any_req_s;
    logic        win_a_s;
    logic [31:0] win_data_s;
    logic [3:0]  win_mask_s;

    // Replace each enabled byte of the current value with the write data; bit i enables byte i.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wr,
                                                input logic [3:0]  en);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                res[i*8 +: 8] = wr[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = cur[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Round-robin winner selection: a tie goes to the source not granted last.
    always_comb begin
        any_req_s = req_a_i | req_b_i;
        win_a_s   = req_a_i & (~req_b_i | ~last_a_q);
        if (win_a_s) begin
            win_data_s = data_a_i;
            win_mask_s = mask_a_i;
        end else begin
            win_data_s = data_b_i;
            win_mask_s = mask_b_i;
        end
    end

    // Next-state logic for the IDLE/BLANK controller.
    always_comb begin
        state_d   = state_q;
        last_a_d  = last_a_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        upd_cnt_d = upd_cnt_q;
        gnt_a_d   = 1'b0;
        gnt_b_d   = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (!freeze_i && any_req_s) begin
                    shadow_d = merge_bytes(disp_q, win_data_s, win_mask_s);
                    gnt_a_d  = win_a_s;
                    gnt_b_d  = ~win_a_s;
                    last_a_d = win_a_s;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_BLANK;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            ST_BLANK: begin
                // Commit happens on the same edge busy falls, so the scanner never shows a half update.
                if (cnt_q != 8'd0) begin
                    cnt_d     = cnt_q - 8'd1;
                end else begin
                    disp_d    = shadow_q;
                    upd_cnt_d = upd_cnt_q + 8'd1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            last_a_q  <= 1'b0;
            cnt_q     <= 8'd0;
            shadow_q  <= INIT_VAL;
            disp_q    <= INIT_VAL;
            upd_cnt_q <= 8'd0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_a_q  <= last_a_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            upd_cnt_q <= upd_cnt_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt_a_o   = gnt_a_q;
    assign gnt_b_o   = gnt_b_q;
    assign busy_o    = busy_q;
    assign z1_o      = disp_q[31:24];
    assign r1_o      = disp_q[23:16];
    assign z2_o      = disp_q[15:8];
    assign r2_o      = disp_q[7:0];
    assign upd_cnt_o = upd_cnt_q;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Directed self-checking bench for display_update_ctrl with hand-computed expected values.
module tb_display_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        req_a, req_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  mask_a, mask_b;
    logic        gnt_a, gnt_b, busy;
    logic [7:0]  z1, r1, z2, r2, upd_cnt;

    int n_cmp = 0;
    int n_err = 0;

    display_update_ctrl #(.BLANK_CYC(4), .INIT_VAL(32'h0000_0000)) dut (
        .clk_i(clk), .rst_ni(rst_n), .freeze_i(freeze),
        .req_a_i(req_a), .data_a_i(data_a), .mask_a_i(mask_a),
        .req_b_i(req_b), .data_b_i(data_b), .mask_b_i(mask_b),
        .gnt_a_o(gnt_a), .gnt_b_o(gnt_b), .busy_o(busy),
        .z1_o(z1), .r1_o(r1), .z2_o(z2), .r2_o(r2), .upd_cnt_o(upd_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] disp();
        return {z1, r1, z2, r2};
    endfunction

    initial begin
        rst_n = 1'b0; freeze = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        data_a = 32'h0; data_b = 32'h0; mask_a = 4'h0; mask_b = 4'h0;
        tick(); tick();
        check_val("rst_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_disp", disp(), 32'h0000_0000);
        check_val("rst_upd", {24'd0, upd_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: full write from A
        req_a = 1'b1; data_a = 32'h1234_5678; mask_a = 4'hF;
        tick();
        check_val("t1_gnt_a", {31'd0, gnt_a}, 32'd1);
        check_val("t1_busy0", {31'd0, busy}, 32'd1);
        req_a = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            check_val("t1_gnt_off", {30'd0, gnt_a, gnt_b}, 32'd0);
            check_val("t1_busy_hi", {31'd0, busy}, 32'd1);
            check_val("t1_disp_hold", disp(), 32'h0000_0000);
        end
        tick();
        check_val("t1_busy_fall", {31'd0, busy}, 32'd0);
        check_val("t1_disp", disp(), 32'h1234_5678);
        check_val("t1_upd", {24'd0, upd_cnt}, 32'd1);

        // 3: masked write from B
        req_b = 1'b1; data_b = 32'hAABB_CCDD; mask_b = 4'b0101;
        tick();
        check_val("t3_gnt_b", {30'd0, gnt_a, gnt_b}, 32'd1);
        req_b = 1'b0; data_b = 32'hFFFF_FFFF; mask_b = 4'hF;
        tick(); tick(); tick(); tick();
        check_val("t3_busy", {31'd0, busy}, 32'd0);
        check_val("t3_disp", disp(), 32'h12BB_56DD);
        check_val("t3_upd", {24'd0, upd_cnt}, 32'd2);

        // 2: both held; last winner was B so A first, then alternate every 5 cycles
        req_a = 1'b1; data_a = 32'hA1A2_A3A4; mask_a = 4'hF;
        req_b = 1'b1; data_b = 32'hB1B2_B3B4; mask_b = 4'hF;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 0) begin
                check_val("t2_gnt", {30'd0, gnt_a, gnt_b}, ((i / 5) % 2 == 0) ? 32'd2 : 32'd1);
            end else begin
                check_val("t2_nognt", {30'd0, gnt_a, gnt_b}, 32'd0);
            end
            check_val("t2_busy", {31'd0, busy}, (i % 5 == 4) ? 32'd0 : 32'd1);
        end
        req_a = 1'b0; req_b = 1'b0;
        check_val("t2_disp", disp(), 32'hB1B2_B3B4);
        check_val("t2_upd", {24'd0, upd_cnt}, 32'd6);

        // 4: freeze blocks grants, release grants next edge
        freeze = 1'b1; req_a = 1'b1; data_a = 32'h1122_3344; mask_a = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("t4_frz_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
            check_val("t4_frz_busy", {31'd0, busy}, 32'd0);
        end
        freeze = 1'b0;
        tick();
        check_val("t4_gnt_a", {30'd0, gnt_a, gnt_b}, 32'd2);
        req_a = 1'b0;
        freeze = 1'b1;
        req_b = 1'b1; data_b = 32'h9999_9999; mask_b = 4'hF;
        tick(); tick(); tick(); tick();
        check_val("t4_frz_commit", disp(), 32'h1122_3344);
        check_val("t4_frz_busy_end", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t4_frz_nogntb", {30'd0, gnt_a, gnt_b}, 32'd0);
        end
        req_b = 1'b0; freeze = 1'b0;
        tick();
        check_val("t4_upd", {24'd0, upd_cnt}, 32'd7);

        // 6: 256 mask-0 writes from A; values unchanged, counter wraps
        data_a = 32'hFFFF_FFFF; mask_a = 4'h0;
        for (int w = 1; w <= 256; w++) begin
            req_a = 1'b1;
            tick();
            check_val("t6_gnt_a", {31'd0, gnt_a}, 32'd1);
            req_a = 1'b0;
            tick(); tick(); tick(); tick();
            check_val("t6_disp", disp(), 32'h1122_3344);
            if (w == 249) begin
                check_val("t6_wrap0", {24'd0, upd_cnt}, 32'd0);
            end
        end
        check_val("t6_upd_end", {24'd0, upd_cnt}, 32'd7);

        // 5: reset during BLANK discards the write
        req_a = 1'b1; data_a = 32'hDEAD_BEEF; mask_a = 4'hF;
        tick();
        check_val("t5_gnt_a", {31'd0, gnt_a}, 32'd1);
        req_a = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
        check_val("t5_rst_disp", disp(), 32'h0000_0000);
        check_val("t5_rst_upd", {24'd0, upd_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("t5_no_commit", disp(), 32'h0000_0000);
            check_val("t5_no_busy", {31'd0, busy}, 32'd0);
        end
        check_val("t5_upd", {24'd0, upd_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
